// File: rtl/fmaresultsign_if.sv
// rtl/fmaresultsign_if.sv - handshake and operand bundle for the FMA result-sign resolver
interface fmaresultsign_if #(
    parameter int TAGW = 8
);
    logic            Flush;
    logic            InValid;
    logic            InReady;
    logic            Ps;
    logic            As;
    logic            InvA;
    logic            AddendGt;
    logic            SumZero;
    logic            NaNIn;
    logic            PInf;
    logic            AInf;
    logic [2:0]      Frm;
    logic [TAGW-1:0] InTag;
    logic            OutValid;
    logic            OutReady;
    logic            Ws;
    logic [TAGW-1:0] OutTag;
    logic [15:0]     CancelCnt;

    modport master (
        output Flush, InValid, Ps, As, InvA, AddendGt, SumZero, NaNIn, PInf, AInf, Frm, InTag, OutReady,
        input  InReady, OutValid, Ws, OutTag, CancelCnt
    );

    modport slave (
        input  Flush, InValid, Ps, As, InvA, AddendGt, SumZero, NaNIn, PInf, AInf, Frm, InTag, OutReady,
        output InReady, OutValid, Ws, OutTag, CancelCnt
    );
endinterface

// File: rtl/fmaresultsign.sv
// rtl/fmaresultsign.sv - 2-stage valid/ready FMA result-sign resolver; FMARSIGN_CANCEL_CNT_EN enables CancelCnt
module fmaresultsign #(
    parameter int TAGW = 8
) (
    input  logic           clk,
    input  logic           resetn,
    fmaresultsign_if.slave bus
);
    typedef struct packed {
        logic            ps;
        logic            addend_s;
        logic            inva;
        logic            agt;
        logic            szero;
        logic            nan;
        logic            pinf;
        logic            ainf;
        logic [2:0]      frm;
        logic [TAGW-1:0] tag;
    } s1_t;

    localparam logic [2:0] FRM_RDN = 3'b010;

    logic            s1_valid;
    s1_t             s1_q;
    s1_t             s1_d;
    logic            s2_valid;
    logic            s2_ws;
    logic [TAGW-1:0] s2_tag;
    logic            s2_adv;
    logic            ws_d;

    // The only input-to-output path: OutReady -> InReady through s2_adv.
    assign s2_adv      = ~s2_valid | bus.OutReady;
    assign bus.InReady = ~s1_valid | s2_adv;

    always_comb begin
        s1_d          = '0;
        s1_d.ps       = bus.Ps;
        s1_d.addend_s = bus.As;
        s1_d.inva     = bus.InvA;
        s1_d.agt      = bus.AddendGt;
        s1_d.szero    = bus.SumZero;
        s1_d.nan      = bus.NaNIn;
        s1_d.pinf     = bus.PInf;
        s1_d.ainf     = bus.AInf;
        s1_d.frm      = bus.Frm;
        s1_d.tag      = bus.InTag;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (bus.Flush) begin
            s1_valid <= 1'b0;
        end else if (bus.InReady) begin
            s1_valid <= bus.InValid;
            if (bus.InValid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Sign priority: NaN is canonical positive; infinities dominate; exact zero
    // from effective subtraction is -0 only when rounding toward negative.
    always_comb begin
        ws_d = s1_q.ps;
        if (s1_q.nan) begin
            ws_d = 1'b0;
        end else if (s1_q.pinf) begin
            ws_d = s1_q.ps;
        end else if (s1_q.ainf) begin
            ws_d = s1_q.addend_s;
        end else if (s1_q.szero) begin
            ws_d = s1_q.inva ? (s1_q.frm == FRM_RDN) : s1_q.addend_s;
        end else if (s1_q.inva && s1_q.agt) begin
            ws_d = s1_q.addend_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            s2_ws    <= 1'b0;
            s2_tag   <= '0;
        end else if (bus.Flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ws  <= ws_d;
                s2_tag <= s1_q.tag;
            end
        end
    end

    assign bus.OutValid = s2_valid;
    assign bus.Ws       = s2_ws;
    assign bus.OutTag   = s2_tag;

`ifdef FMARSIGN_CANCEL_CNT_EN
    logic        cancel_d;
    logic        s2_cancel;
    logic [15:0] cancel_cnt;

    assign cancel_d = s1_q.szero & s1_q.inva & ~s1_q.nan & ~s1_q.pinf & ~s1_q.ainf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_cancel <= 1'b0;
        end else if (!bus.Flush && s2_adv && s1_valid) begin
            s2_cancel <= cancel_d;
        end
    end

    // Counts accepted outputs, so a result taken in a Flush cycle still counts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cancel_cnt <= 16'h0000;
        end else if (s2_valid && bus.OutReady && s2_cancel && (cancel_cnt != 16'hFFFF)) begin
            cancel_cnt <= cancel_cnt + 16'd1;
        end
    end

    assign bus.CancelCnt = cancel_cnt;
`else
    assign bus.CancelCnt = 16'h0000;
`endif
endmodule
